slow_sequencer: RTL and testbench
=================================

// Module: slow_sequencer
// PURPOSE
//  Throttle sequencer for the WarpSE CPLD. It consumes the slow-device enable
//  flags and SlowTimeout written through the settings register, detects accesses
//  to enabled slow peripherals, and holds Slow (CPU at Mac-native speed) for a
//  programmable window after the last such access.
//  Sits between the settings register, the address decoder and the clock-switch
//  logic. SlowClockGate qualifies the gated-clock request.
// PARAMETERS
//  TSHIFT  4  hold window = SlowTimeout << TSHIFT timer ticks; counter width 4+TSHIFT
// PORTS
//  CLK            in   1  system clock
//  nPOR           in   1  reset, asynchronous, active-low
//  BACT           in   1  CPU bus cycle active
//  TimerTick      in   1  one-CLK pulse, periodic timebase
//  IACKCS,VIACS,IWMCS,SCCCS,SCSICS,SndCS  in  1 each  decoded peripheral selects
//  SlowIACK,SlowVIA,SlowIWM,SlowSCC,SlowSCSI,SlowSnd  in  1 each  per-device enables
//  SlowClockGate  in   1  gated-clock request enable
//  SlowTimeout    in   4  hold-window code; 4'hF = always slow
//  Slow           out  1  run CPU slow (registered)
//  SlowGateReq    out  1  Slow && SlowClockGate (registered)
//  SlowBusy       out  1  hold counter nonzero (registered)
// BEHAVIOUR
//  Reset: state IDLE, CNT=0, BACTr=0, Slow=0, SlowGateReq=0, SlowBusy=0.
//  BACTr <= BACT every CLK. Start = BACT && !BACTr.
//  Hit = Start && |(selects & matching enables). Evaluated only at Start.
//  Load value L = {SlowTimeout, TSHIFT zero bits}.
//  States:
//   IDLE:   Slow=0. If SlowTimeout==F -> FORCED. Else if Hit -> HOLD, CNT<=L.
//   HOLD:   Slow=1. Hit -> CNT<=L (reload wins over a same-cycle tick).
//           Else if TimerTick && CNT!=0 -> CNT<=CNT-1. No underflow below 0.
//           CNT==0 && !BACT && !Hit -> IDLE. CNT==0 && BACT -> stay (never drop mid-cycle).
//           SlowTimeout becomes F -> FORCED.
//   FORCED: Slow=1, CNT held. SlowTimeout!=F -> HOLD with CNT<=L; exits via HOLD rules.
//  Latency: Slow rises on the CLK edge after the Start cycle, so it is high one
//  CLK after BACT rises. Slow falls on the edge after CNT==0 && !BACT.
//  SlowTimeout==0: Slow covers only the triggering bus cycle and drops after BACT falls.
//  SlowTimeout changes during HOLD do not affect CNT until the next reload.
//  Disabled device (enable=0) or no select at Start: no trigger, even in HOLD.
//  SlowGateReq and SlowBusy are registered with Slow. They update on the same edge.
//  nPOR low mid-HOLD: immediate return to reset values, regardless of CLK.
// TESTING
//  1 Reset; Timeout=2, TSHIFT=4, VIA access (VIACS=1, SlowVIA=1):
//    Slow=1 one CLK after BACT rises, CNT=32. Slow drops on the edge after the
//    32nd tick, with BACT low.
//  2 Timeout=0, SCC access with SlowSCC=1, BACT high 5 CLK:
//    Slow high the whole cycle, low on the edge after BACT falls.
//  3 Retrigger: a second IWM access arrives at CNT=3 together with a TimerTick.
//    CNT reloads to L, not L-1. Slow stays high throughout.
//  4 CNT reaches 0 while BACT=1 for 4 more CLK: Slow stays 1 until BACT falls,
//    then 0 one CLK later.
//  5 Timeout=F: Slow=1 with no access. Write 1: HOLD with CNT=16, then IDLE after
//    16 ticks. SCSICS access with SlowSCSI=0: Slow stays 0.
//  6 Assert nPOR low asynchronously mid-HOLD: Slow, SlowBusy and SlowGateReq go 0
//    before the next CLK. SlowClockGate=1 during HOLD: SlowGateReq mirrors Slow.

Source files
------------

// File: rtl/slow_sequencer.sv
// Throttle sequencer: detects bus cycles that hit enabled slow peripherals and
// holds Slow for a programmable number of timer ticks after the last such hit.
module slow_sequencer #(
  parameter int TSHIFT = 4
) (
  input  logic                CLK,
  input  logic                nPOR,
  input  logic                BACT,
  input  logic                TimerTick,
  input  logic                IACKCS,
  input  logic                VIACS,
  input  logic                IWMCS,
  input  logic                SCCCS,
  input  logic                SCSICS,
  input  logic                SndCS,
  input  logic                SlowIACK,
  input  logic                SlowVIA,
  input  logic                SlowIWM,
  input  logic                SlowSCC,
  input  logic                SlowSCSI,
  input  logic                SlowSnd,
  input  logic                SlowClockGate,
  input  logic [3:0]          SlowTimeout,
  output logic                Slow,
  output logic                SlowGateReq,
  output logic                SlowBusy,
  output logic [1:0]          dbg_state,
  output logic [4+TSHIFT-1:0] dbg_cnt
);

  localparam int CW = 4 + TSHIFT;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_FORCED = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            bact_q, bact_d;
  logic            slow_q, slow_d;
  logic            gate_q, gate_d;
  logic            busy_q, busy_d;

  logic [5:0]      sel;
  logic [5:0]      en;
  logic            start;
  logic            hit;
  logic            forced;
  logic [CW-1:0]   load;

  assign sel = {SndCS, SCSICS, SCCCS, IWMCS, VIACS, IACKCS};
  assign en  = {SlowSnd, SlowSCSI, SlowSCC, SlowIWM, SlowVIA, SlowIACK};

  always_comb begin
    bact_d = BACT;
    start  = BACT && !bact_q;
    hit    = start && |(sel & en);
    forced = (SlowTimeout == 4'hF);
    load   = {SlowTimeout, {TSHIFT{1'b0}}};

    state_d = state_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (forced) begin
          state_d = ST_FORCED;
        end else if (hit) begin
          state_d = ST_HOLD;
          cnt_d   = load;
        end
      end
      ST_HOLD: begin
        if (forced) begin
          state_d = ST_FORCED;
        end else if (hit) begin
          // A fresh hit restarts the window even if a tick lands on the same cycle.
          cnt_d = load;
        end else begin
          if (TimerTick && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;
          // Never release Slow in the middle of a bus cycle.
          if ((cnt_q == '0) && !BACT) state_d = ST_IDLE;
        end
      end
      ST_FORCED: begin
        if (!forced) begin
          state_d = ST_HOLD;
          cnt_d   = load;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    slow_d = (state_d != ST_IDLE);
    gate_d = slow_d && SlowClockGate;
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bact_q  <= 1'b0;
      slow_q  <= 1'b0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bact_q  <= bact_d;
      slow_q  <= slow_d;
      gate_q  <= gate_d;
      busy_q  <= busy_d;
    end
  end

  assign Slow        = slow_q;
  assign SlowGateReq = gate_q;
  assign SlowBusy    = busy_q;
  assign dbg_state   = state_q;
  assign dbg_cnt     = cnt_q;

endmodule

// File: tb/tb_slow_sequencer.sv
// Bench for slow_sequencer: a vector table for trigger decoding plus directed
// multi-cycle sequences, all checked through an expected-value queue.
module tb_slow_sequencer;

  localparam logic [5:0] IACK = 6'b000001;
  localparam logic [5:0] VIA  = 6'b000010;
  localparam logic [5:0] IWM  = 6'b000100;
  localparam logic [5:0] SCC  = 6'b001000;
  localparam logic [5:0] SCSI = 6'b010000;
  localparam logic [5:0] SND  = 6'b100000;

  logic       clk;
  logic       n_por;
  logic       bact;
  logic       tick;
  logic [5:0] sel;
  logic [5:0] en;
  logic       gate;
  logic [3:0] tmo;
  logic       slow;
  logic       slow_gate_req;
  logic       slow_busy;
  logic [1:0] dbg_state;
  logic [7:0] dbg_cnt;

  int n_cmp;
  int n_bad;

  // {slow, gate_req, busy, cnt}
  logic [10:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic [5:0] sel;
    logic [5:0] en;
    logic [3:0] tmo;
    logic       gate;
    logic       exp_slow;
    logic       exp_gate;
    logic       exp_busy;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[9];

  slow_sequencer #(.TSHIFT(4)) dut (
    .CLK          (clk),
    .nPOR         (n_por),
    .BACT         (bact),
    .TimerTick    (tick),
    .IACKCS       (sel[0]),
    .VIACS        (sel[1]),
    .IWMCS        (sel[2]),
    .SCCCS        (sel[3]),
    .SCSICS       (sel[4]),
    .SndCS        (sel[5]),
    .SlowIACK     (en[0]),
    .SlowVIA      (en[1]),
    .SlowIWM      (en[2]),
    .SlowSCC      (en[3]),
    .SlowSCSI     (en[4]),
    .SlowSnd      (en[5]),
    .SlowClockGate(gate),
    .SlowTimeout  (tmo),
    .Slow         (slow),
    .SlowGateReq  (slow_gate_req),
    .SlowBusy     (slow_busy),
    .dbg_state    (dbg_state),
    .dbg_cnt      (dbg_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no end of test, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input string name, input logic s, input logic g,
                          input logic b, input int cnt);
    logic [7:0] c;
    c = cnt[7:0];
    exp_q.push_back({s, g, b, c});
    name_q.push_back(name);
  endtask

  // One clock; compare the oldest pending expectation just after the edge.
  task automatic step();
    logic [10:0] e;
    string       n;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      chk(n, {21'd0, slow, slow_gate_req, slow_busy, dbg_cnt}, {21'd0, e});
    end
  endtask

  task automatic reset_dut();
    bact = 1'b0; tick = 1'b0; sel = '0; en = '0; gate = 1'b0; tmo = 4'd0;
    exp_q.delete();
    name_q.delete();
    n_por = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_outs", {29'd0, slow, slow_gate_req, slow_busy}, 32'd0);
    chk("reset_state", {22'd0, dbg_state, dbg_cnt}, 32'd0);
    n_por = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    n_por = 1'b0;
    bact = 1'b0; tick = 1'b0; sel = '0; en = '0; gate = 1'b0; tmo = 4'd0;

    // Trigger decoding at the start of a bus cycle.
    vecs[0] = '{VIA,        VIA,        4'd2,  1'b0, 1'b1, 1'b0, 1'b1, 8'd32};
    vecs[1] = '{SCC,        VIA,        4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[2] = '{6'b000000,  6'b111111,  4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[3] = '{IACK,       IACK,       4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[4] = '{SND,        SND,        4'd7,  1'b1, 1'b1, 1'b1, 1'b1, 8'd112};
    vecs[5] = '{SCSI,       6'b000000,  4'd4,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[6] = '{6'b111111,  SCSI,       4'hF,  1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[7] = '{IWM,        IWM | SCC,  4'd1,  1'b0, 1'b1, 1'b0, 1'b1, 8'd16};
    vecs[8] = '{SCSI | SCC, SCSI,       4'hE,  1'b1, 1'b1, 1'b1, 1'b1, 8'd224};

    for (int i = 0; i < 9; i++) begin
      reset_dut();
      sel = vecs[i].sel; en = vecs[i].en; tmo = vecs[i].tmo; gate = vecs[i].gate;
      bact = 1'b1;
      push_exp($sformatf("vec%0d", i), vecs[i].exp_slow, vecs[i].exp_gate,
               vecs[i].exp_busy, int'(vecs[i].exp_cnt));
      step();
      bact = 1'b0; sel = '0;
      step();
    end

    // VIA access with a 32-tick window, released only after the last tick.
    reset_dut();
    tmo = 4'd2; en = VIA; sel = VIA; bact = 1'b1;
    push_exp("t1_rise", 1, 0, 1, 32); step();
    sel = '0;
    push_exp("t1_bact", 1, 0, 1, 32); step();
    bact = 1'b0;
    push_exp("t1_idle", 1, 0, 1, 32); step();
    for (int i = 1; i <= 32; i++) begin
      tick = 1'b1;
      push_exp("t1_tick", 1, 0, (32 - i) != 0, 32 - i); step();
      tick = 1'b0;
      push_exp("t1_gap", i < 32, 0, (32 - i) != 0, 32 - i); step();
    end
    push_exp("t1_stay_idle", 0, 0, 0, 0); step();

    // Zero timeout: Slow spans only the triggering bus cycle.
    reset_dut();
    tmo = 4'd0; en = SCC; sel = SCC; bact = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_exp("t2_cycle", 1, 0, 0, 0); step();
    end
    bact = 1'b0; sel = '0;
    push_exp("t2_drop", 0, 0, 0, 0); step();

    // Retrigger with a coincident tick reloads to the full window.
    reset_dut();
    tmo = 4'd2; en = IWM; sel = IWM; bact = 1'b1;
    push_exp("t3_rise", 1, 0, 1, 32); step();
    bact = 1'b0; sel = '0;
    for (int i = 1; i <= 29; i++) begin
      tick = 1'b1;
      push_exp("t3_count", 1, 0, 1, 32 - i); step();
    end
    bact = 1'b1; sel = IWM; tick = 1'b1;
    push_exp("t3_reload", 1, 0, 1, 32); step();
    bact = 1'b0; sel = '0; tick = 1'b0;
    push_exp("t3_after", 1, 0, 1, 32); step();
    tmo = 4'd5; tick = 1'b1;
    push_exp("t3_tmo_change", 1, 0, 1, 31); step();
    bact = 1'b1; sel = SCC;
    push_exp("t3_disabled_hit", 1, 0, 1, 30); step();
    bact = 1'b0; sel = '0; tick = 1'b0;
    push_exp("t3_end", 1, 0, 1, 30); step();

    // Window expires while the bus cycle is still active.
    reset_dut();
    tmo = 4'd1; en = VIA; sel = VIA; bact = 1'b1;
    push_exp("t4_rise", 1, 0, 1, 16); step();
    sel = '0;
    for (int i = 1; i <= 16; i++) begin
      tick = 1'b1;
      push_exp("t4_count", 1, 0, (16 - i) != 0, 16 - i); step();
    end
    for (int k = 0; k < 4; k++) begin
      tick = (k == 1);
      push_exp("t4_bact_hold", 1, 0, 0, 0); step();
    end
    bact = 1'b0; tick = 1'b0;
    push_exp("t4_drop", 0, 0, 0, 0); step();

    // Forced mode, hold of the count, and exit through the hold window.
    reset_dut();
    tmo = 4'hF;
    push_exp("t5_forced", 1, 0, 0, 0); step();
    push_exp("t5_forced2", 1, 0, 0, 0); step();
    tmo = 4'd1;
    push_exp("t5_to_hold", 1, 0, 1, 16); step();
    tick = 1'b1;
    push_exp("t5_t1", 1, 0, 1, 15); step();
    push_exp("t5_t2", 1, 0, 1, 14); step();
    tmo = 4'hF;
    push_exp("t5_cnt_held", 1, 0, 1, 14); step();
    push_exp("t5_cnt_held2", 1, 0, 1, 14); step();
    tmo = 4'd1; tick = 1'b0;
    push_exp("t5_reload", 1, 0, 1, 16); step();
    for (int i = 1; i <= 16; i++) begin
      tick = 1'b1;
      push_exp("t5_count", 1, 0, (16 - i) != 0, 16 - i); step();
    end
    tick = 1'b0;
    push_exp("t5_exit", 0, 0, 0, 0); step();
    en = VIA | SCC; sel = SCSI; bact = 1'b1;
    push_exp("t5_scsi_off", 0, 0, 0, 0); step();
    bact = 1'b0; sel = '0;
    push_exp("t5_scsi_off2", 0, 0, 0, 0); step();

    // Gate request tracks Slow and SlowClockGate; async reset mid-window.
    reset_dut();
    tmo = 4'd2; en = VIA; sel = VIA; gate = 1'b1; bact = 1'b1;
    push_exp("t6_gate_on", 1, 1, 1, 32); step();
    gate = 1'b0; sel = '0; bact = 1'b0;
    push_exp("t6_gate_off", 1, 0, 1, 32); step();
    gate = 1'b1;
    push_exp("t6_gate_back", 1, 1, 1, 32); step();
    #2;
    n_por = 1'b0;
    #1;
    chk("t6_async_outs", {29'd0, slow, slow_gate_req, slow_busy}, 32'd0);
    chk("t6_async_state", {22'd0, dbg_state, dbg_cnt}, 32'd0);
    @(negedge clk);
    n_por = 1'b1;
    push_exp("t6_after_reset", 0, 0, 0, 0); step();

    if (exp_q.size() != 0) begin
      chk("queue_drained", exp_q.size(), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
